// File: rtl/control_sequencer.sv
// Hardwired control unit for the Phase-1 CPU datapath.
// Steps the fetch phases (T0-T2) and the execute phases (T3-T5) of
// 3-register ALU instructions and drives every datapath strobe plus the
// select-and-encode controls. Outputs are decoded from the current state.
// The only exceptions are T3, which is gated by the opcode class, and
// Alu_op in T4, which passes the opcode straight through.
module control_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Mem_ready,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic [4:0]       Alu_op,
  output logic             Illegal,
  output logic             Halted,
  output logic [CNT_W-1:0] Instr_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T0,
    ST_T1,
    ST_T2,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_HALT
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [4:0]  opcode;
  logic [31:0] alu_table;
  logic        is_alu;
  logic        is_nop;
  logic        is_halt;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  // The register fields are decoded by select-and-encode, not by this block.
  assign unused_ir = ^IR[26:0];

  // One entry per opcode value: set for the ALU group add..shl (00011..01011).
  for (genvar gi = 0; gi < 32; gi++) begin : g_alu_table
    assign alu_table[gi] = (gi >= 3) && (gi <= 11);
  end

  assign is_alu  = alu_table[opcode];
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);

  assign Instr_count = count_reg;

  // State and retired-instruction counter. Reset has priority over everything.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Next-state, retire counting and state-decoded strobes.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    Alu_op     = 5'b0;
    Illegal    = 1'b0;
    Halted     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (Run) state_next = ST_T0;
      end

      // Send PC to MAR and start PC+1 in Z.
      ST_T0: begin
        PCout      = 1'b1;
        MARin      = 1'b1;
        IncPC      = 1'b1;
        Zin        = 1'b1;
        state_next = ST_T1;
      end

      // Write PC+1 back and hold the memory read until the data is valid.
      ST_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (Mem_ready) state_next = ST_T2;
      end

      ST_T2: begin
        MDRout     = 1'b1;
        IRin       = 1'b1;
        state_next = ST_T3;
      end

      // Decode. Only ALU ops continue; nop and illegal opcodes retire here,
      // and halt retires into the HALT state.
      ST_T3: begin
        if (is_alu) begin
          Grb        = 1'b1;
          Rout       = 1'b1;
          Yin        = 1'b1;
          state_next = ST_T4;
        end else if (is_halt) begin
          count_next = count_reg + CNT_W'(1);
          state_next = ST_HALT;
        end else begin
          Illegal    = ~is_nop;
          count_next = count_reg + CNT_W'(1);
          state_next = Run ? ST_T0 : ST_IDLE;
        end
      end

      ST_T4: begin
        Grc        = 1'b1;
        Rout       = 1'b1;
        Zin        = 1'b1;
        Alu_op     = opcode;
        state_next = ST_T5;
      end

      // Write the result to Ra and retire.
      ST_T5: begin
        Zlowout    = 1'b1;
        Gra        = 1'b1;
        Rin        = 1'b1;
        count_next = count_reg + CNT_W'(1);
        state_next = Run ? ST_T0 : ST_IDLE;
      end

      ST_HALT: begin
        Halted = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised scoreboard bench for control_sequencer.
// The stimulus side walks instructions through the phase table and pushes
// the expected output word for every cycle. A forked monitor pops one entry
// per falling edge and compares it with the DUT outputs.
module tb_control_sequencer;

  localparam int CNT_W = 4;

  localparam logic [17:0] B_PCOUT   = 18'h20000;
  localparam logic [17:0] B_MARIN   = 18'h10000;
  localparam logic [17:0] B_INCPC   = 18'h08000;
  localparam logic [17:0] B_ZIN     = 18'h04000;
  localparam logic [17:0] B_ZLOWOUT = 18'h02000;
  localparam logic [17:0] B_PCIN    = 18'h01000;
  localparam logic [17:0] B_READ    = 18'h00800;
  localparam logic [17:0] B_MDRIN   = 18'h00400;
  localparam logic [17:0] B_MDROUT  = 18'h00200;
  localparam logic [17:0] B_IRIN    = 18'h00100;
  localparam logic [17:0] B_YIN     = 18'h00080;
  localparam logic [17:0] B_GRA     = 18'h00040;
  localparam logic [17:0] B_GRB     = 18'h00020;
  localparam logic [17:0] B_GRC     = 18'h00010;
  localparam logic [17:0] B_RIN     = 18'h00008;
  localparam logic [17:0] B_ROUT    = 18'h00004;
  localparam logic [17:0] B_ILLEGAL = 18'h00002;
  localparam logic [17:0] B_HALTED  = 18'h00001;

  localparam logic [17:0] W_T0   = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
  localparam logic [17:0] W_T1   = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [17:0] W_T2   = B_MDROUT | B_IRIN;
  localparam logic [17:0] W_T3A  = B_GRB | B_ROUT | B_YIN;
  localparam logic [17:0] W_T4   = B_GRC | B_ROUT | B_ZIN;
  localparam logic [17:0] W_T5   = B_ZLOWOUT | B_GRA | B_RIN;

  localparam int C_ALU = 0;
  localparam int C_NOP = 1;
  localparam int C_HLT = 2;
  localparam int C_ILL = 3;

  typedef struct packed {
    logic [17:0]      w;
    logic [4:0]       alu;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       ph;
  } exp_t;

  logic             Clock;
  logic             Reset;
  logic             Run;
  logic             Mem_ready;
  logic [31:0]      IR;
  logic             PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin;
  logic             MDRout, IRin, Yin, Gra, Grb, Grc, Rin, Rout;
  logic [4:0]       Alu_op;
  logic             Illegal;
  logic             Halted;
  logic [CNT_W-1:0] Instr_count;

  exp_t exp_q[$];
  int   exp_cnt;
  bit   in_idle;
  int   checks;
  int   failures;
  int   cycle_no;

  control_sequencer #(.CNT_W(CNT_W)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Run         (Run),
    .Mem_ready   (Mem_ready),
    .IR          (IR),
    .PCout       (PCout),
    .MARin       (MARin),
    .IncPC       (IncPC),
    .Zin         (Zin),
    .Zlowout     (Zlowout),
    .PCin        (PCin),
    .Read        (Read),
    .MDRin       (MDRin),
    .MDRout      (MDRout),
    .IRin        (IRin),
    .Yin         (Yin),
    .Gra         (Gra),
    .Grb         (Grb),
    .Grc         (Grc),
    .Rin         (Rin),
    .Rout        (Rout),
    .Alu_op      (Alu_op),
    .Illegal     (Illegal),
    .Halted      (Halted),
    .Instr_count (Instr_count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic string ph_name(input logic [3:0] ph);
    case (ph)
      4'd0:    return "IDLE";
      4'd1:    return "T0";
      4'd2:    return "T1";
      4'd3:    return "T2";
      4'd4:    return "T3";
      4'd5:    return "T4";
      4'd6:    return "T5";
      default: return "HALT";
    endcase
  endfunction

  function automatic int op_class(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return C_ALU;
    if (op == 5'd26) return C_NOP;
    if (op == 5'd27) return C_HLT;
    return C_ILL;
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] rword();
    return 32'($urandom);
  endfunction

  // Drive one cycle of inputs and record what the DUT must show this cycle.
  task automatic cyc(input logic rst, input logic run, input logic mr,
                     input logic [31:0] ir, input logic [17:0] w,
                     input logic [4:0] alu, input logic [3:0] ph);
    exp_t e;
    logic [31:0] cnt_now;
    Reset     = rst;
    Run       = run;
    Mem_ready = mr;
    IR        = ir;
    cnt_now   = 32'(exp_cnt);
    e.w   = w;
    e.alu = alu;
    e.cnt = cnt_now[CNT_W-1:0];
    e.ph  = ph;
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic retire(input bit run_after);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    in_idle = !run_after;
  endtask

  // Carry one instruction through the phase table.
  // abort_at: 0 none, 1 reset on the first T1 wait cycle, 4 reset during T4.
  task automatic instr(input logic [31:0] ir, input int wait_cycles,
                       input bit run_after, input int abort_at);
    int cls;
    int n;
    cls = op_class(ir[31:27]);
    $display("instr ir=%08h class=%0d wait=%0d run_after=%0b abort=%0d count=%0d",
             ir, cls, wait_cycles, run_after, abort_at, exp_cnt);
    if (in_idle) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, rbit(), rword(), 18'h0, 5'd0, 4'd0);
      cyc(1'b0, 1'b1, rbit(), rword(), 18'h0, 5'd0, 4'd0);
    end
    in_idle = 1'b0;
    cyc(1'b0, rbit(), rbit(), rword(), W_T0, 5'd0, 4'd1);
    for (int w = 0; w < wait_cycles; w++) begin
      if (abort_at == 1) begin
        cyc(1'b1, 1'b1, 1'b0, rword(), W_T1, 5'd0, 4'd2);
        exp_cnt = 0;
        in_idle = 1'b1;
        return;
      end
      cyc(1'b0, rbit(), 1'b0, rword(), W_T1, 5'd0, 4'd2);
    end
    cyc(1'b0, rbit(), 1'b1, rword(), W_T1, 5'd0, 4'd2);
    cyc(1'b0, rbit(), rbit(), rword(), W_T2, 5'd0, 4'd3);
    case (cls)
      C_ALU: begin
        cyc(1'b0, rbit(), rbit(), ir, W_T3A, 5'd0, 4'd4);
        if (abort_at == 4) begin
          cyc(1'b1, 1'b1, rbit(), ir, W_T4, ir[31:27], 4'd5);
          exp_cnt = 0;
          in_idle = 1'b1;
          return;
        end
        cyc(1'b0, rbit(), rbit(), ir, W_T4, ir[31:27], 4'd5);
        cyc(1'b0, run_after, rbit(), ir, W_T5, 5'd0, 4'd6);
        retire(run_after);
      end
      C_NOP: begin
        cyc(1'b0, run_after, rbit(), ir, 18'h0, 5'd0, 4'd4);
        retire(run_after);
      end
      C_ILL: begin
        cyc(1'b0, run_after, rbit(), ir, B_ILLEGAL, 5'd0, 4'd4);
        retire(run_after);
      end
      default: begin
        cyc(1'b0, run_after, rbit(), ir, 18'h0, 5'd0, 4'd4);
        retire(1'b1);
        n = $urandom_range(2, 4);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, rbit(), rword(), B_HALTED, 5'd0, 4'd7);
        cyc(1'b1, 1'b1, rbit(), rword(), B_HALTED, 5'd0, 4'd7);
        exp_cnt = 0;
        in_idle = 1'b1;
      end
    endcase
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    logic [31:0] r;
    r = rword();
    return {op, r[26:0]};
  endfunction

  function automatic logic [4:0] pick_illegal();
    logic [4:0] op;
    op = 5'($urandom_range(0, 31));
    while (op_class(op) != C_ILL) op = 5'($urandom_range(0, 31));
    return op;
  endfunction

  // Bound on the whole run in case the DUT or bench wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_cnt   = 0;
    in_idle   = 1'b1;
    checks    = 0;
    failures  = 0;
    cycle_no  = 0;
    Reset     = 1'b1;
    Run       = 1'b0;
    Mem_ready = 1'b0;
    IR        = 32'h0;

    fork
      begin : monitor
        exp_t        e;
        logic [17:0] act_w;
        forever begin
          @(negedge Clock);
          cycle_no++;
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_w = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                     MDRout, IRin, Yin, Gra, Grb, Grc, Rin, Rout, Illegal, Halted};
            checks++;
            if (act_w !== e.w || Alu_op !== e.alu || Instr_count !== e.cnt) begin
              failures++;
              $display("FAIL cycle%0d %s: got strobes=%05h alu=%02h cnt=%0d required strobes=%05h alu=%02h cnt=%0d",
                       cycle_no, ph_name(e.ph), act_w, Alu_op, Instr_count, e.w, e.alu, e.cnt);
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge Clock);
    #1;
    // Reset state: IDLE, all outputs 0, count 0, with Run high during reset.
    cyc(1'b1, 1'b1, 1'b1, rword(), 18'h0, 5'd0, 4'd0);

    instr(32'h28918000, 0, 1'b1, 0);          // and R1,R2,R3
    instr(32'h28918000, 3, 1'b1, 0);          // three-cycle memory wait
    instr(32'h00000000, 0, 1'b1, 0);          // ld: illegal
    instr(mk_ir(5'd26), 1, 1'b1, 0);          // nop
    instr(32'hD8000000, 0, 1'b1, 0);          // halt, then reset
    instr(mk_ir(5'd3), 0, 1'b1, 0);
    instr(mk_ir(5'd4), 0, 1'b1, 4);           // reset during T4
    instr(mk_ir(5'd6), 2, 1'b1, 1);           // reset during T1 wait
    for (int i = 0; i < 15; i++) instr(mk_ir(5'd26), 0, 1'b1, 0);
    instr(mk_ir(5'd3), 0, 1'b0, 0);           // count wraps, Run dropped
    instr(mk_ir(5'd11), 0, 1'b1, 0);          // restart from IDLE

    for (int i = 0; i < 60; i++) begin
      int          r;
      int          wc;
      bit          ra;
      logic [31:0] ir;
      int          ab;
      r  = $urandom_range(0, 99);
      wc = $urandom_range(0, 3);
      ra = ($urandom_range(0, 99) < 80);
      ab = 0;
      if (r < 60)      ir = mk_ir(5'($urandom_range(3, 11)));
      else if (r < 72) ir = mk_ir(5'd26);
      else if (r < 88) ir = mk_ir(pick_illegal());
      else if (r < 93) ir = mk_ir(5'd27);
      else begin
        ir = mk_ir(5'($urandom_range(3, 11)));
        ab = (r < 96) ? 4 : 1;
        if (ab == 1 && wc == 0) wc = 1;
      end
      instr(ir, wc, ra, ab);
    end
    cyc(1'b0, 1'b0, 1'b0, rword(), in_idle ? 18'h0 : W_T0, 5'd0, in_idle ? 4'd0 : 4'd1);

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge Clock);
    @(posedge Clock);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
